// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared constants and FSM state type for the time_keeper block
package clock_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [2*DIGIT_W-1:0] SEC_MAX = 8'h59;
    localparam logic [2*DIGIT_W-1:0] MIN_MAX = 8'h59;
    localparam logic [2*DIGIT_W-1:0] HR_MAX  = 8'h23;

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter that wraps from MAX back to 00
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [2*DIGIT_W-1:0] MAX = 8'h59
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic                   i_inc,
    output logic [2*DIGIT_W-1:0]   o_value,
    output logic                   o_wrap
);

    logic [DIGIT_W-1:0] r_tens;
    logic [DIGIT_W-1:0] r_units;
    logic [DIGIT_W-1:0] w_tens_nx;
    logic [DIGIT_W-1:0] w_units_nx;
    logic               w_at_max;

    assign o_value  = {r_tens, r_units};
    assign w_at_max = (o_value == MAX);
    assign o_wrap   = i_inc && w_at_max;

    always_comb begin
        w_tens_nx  = r_tens;
        w_units_nx = r_units + 1'b1;
        if (w_at_max) begin
            w_tens_nx  = '0;
            w_units_nx = '0;
        end else if (r_units == 4'd9) begin
            w_tens_nx  = r_tens + 1'b1;
            w_units_nx = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tens  <= '0;
            r_units <= '0;
        end else if (i_clr) begin
            r_tens  <= '0;
            r_units <= '0;
        end else if (i_inc) begin
            r_tens  <= w_tens_nx;
            r_units <= w_units_nx;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - 24-hour BCD clock driven by an asynchronous 1 Hz input, with SET mode
// Optional alarm comparator is built when ALARM_EN is defined.
module time_keeper
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TICK_DIV    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sec_clk_in,
    input  logic       i_set_mode,
    input  logic       i_inc_min,
    input  logic       i_inc_hr,
`ifdef ALARM_EN
    input  logic [7:0] i_alarm_hr_bcd,
    input  logic [7:0] i_alarm_min_bcd,
    input  logic       i_alarm_arm,
    output logic       o_alarm_out,
`endif
    output logic [7:0] o_hours_bcd,
    output logic [7:0] o_minutes_bcd,
    output logic [7:0] o_seconds_bcd,
    output logic       o_sec_tick,
    output logic       o_day_rollover
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [PW-1:0]          r_pre;
    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_sec_tick;
    logic                   r_day_roll;

    logic w_sync_out;
    logic w_edge;
    logic w_pre_last;
    logic w_tick;
    logic w_in_run;
    logic w_in_set;
    logic w_run_tick;
    logic w_sec_wrap;
    logic w_min_wrap;
    logic w_hr_wrap;
    logic w_min_inc;
    logic w_hr_inc;

    // Flops preset to 1 so an input already high at reset release is not seen as an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
            r_hist <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sec_clk_in};
            r_hist <= w_sync_out;
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_edge     = w_sync_out & ~r_hist;
    assign w_pre_last = (r_pre == PW'(TICK_DIV - 1));
    assign w_tick     = w_edge & w_pre_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (i_set_mode) begin
            r_pre <= '0;
        end else if (w_edge) begin
            r_pre <= w_pre_last ? '0 : r_pre + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = RUN;
        if (i_set_mode) begin
            w_next_state = SET;
        end
    end

    always_comb begin
        w_in_run = 1'b0;
        w_in_set = 1'b0;
        case (r_state)
            RUN:     w_in_run = 1'b1;
            SET:     w_in_set = 1'b1;
            default: w_in_run = 1'b0;
        endcase
    end

    // A tick arriving while set_mode is already requested is dropped in favour of SET
    assign w_run_tick = w_tick & w_in_run & ~i_set_mode;
    assign w_min_inc  = (w_run_tick & w_sec_wrap) | (w_in_set & i_inc_min);
    assign w_hr_inc   = (w_run_tick & w_min_wrap) | (w_in_set & i_inc_hr);

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (i_set_mode),
        .i_inc   (w_run_tick),
        .o_value (o_seconds_bcd),
        .o_wrap  (w_sec_wrap)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_inc   (w_min_inc),
        .o_value (o_minutes_bcd),
        .o_wrap  (w_min_wrap)
    );

    bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_inc   (w_hr_inc),
        .o_value (o_hours_bcd),
        .o_wrap  (w_hr_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec_tick <= 1'b0;
            r_day_roll <= 1'b0;
        end else begin
            r_sec_tick <= w_run_tick;
            r_day_roll <= w_run_tick & w_hr_wrap;
        end
    end

    assign o_sec_tick     = r_sec_tick;
    assign o_day_rollover = r_day_roll;

`ifdef ALARM_EN
    logic r_alarm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alarm <= 1'b0;
        end else begin
            r_alarm <= i_alarm_arm && w_in_run
                       && (o_hours_bcd == i_alarm_hr_bcd)
                       && (o_minutes_bcd == i_alarm_min_bcd);
        end
    end

    assign o_alarm_out = r_alarm;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - self-checking bench for time_keeper with an expected-time scoreboard
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sec_clk = 1'b0;
    logic       set_mode = 1'b0;
    logic       inc_min = 1'b0;
    logic       inc_hr = 1'b0;
    logic [7:0] hrs;
    logic [7:0] mins;
    logic [7:0] secs;
    logic       sec_tick;
    logic       day_roll;
`ifdef ALARM_EN
    logic [7:0] al_hr = 8'h00;
    logic [7:0] al_min = 8'h01;
    logic       al_arm = 1'b0;
    logic       al_out;
    logic       alarm_at_tick;
    logic       alarm_after_tick;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_tick_seen = 0;
    int          n_roll_seen = 0;
    int          base_tick;
    int          base_roll;
    int          cnt;
    int          h = 0;
    int          m = 0;
    int          s = 0;
    logic [24:0] sb_q[$];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sec_tick === 1'b1) n_tick_seen++;
        if (day_roll === 1'b1) n_roll_seen++;
    end

    time_keeper #(.SYNC_STAGES(2), .TICK_DIV(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_sec_clk_in   (sec_clk),
        .i_set_mode     (set_mode),
        .i_inc_min      (inc_min),
        .i_inc_hr       (inc_hr),
`ifdef ALARM_EN
        .i_alarm_hr_bcd (al_hr),
        .i_alarm_min_bcd(al_min),
        .i_alarm_arm    (al_arm),
        .o_alarm_out    (al_out),
`endif
        .o_hours_bcd    (hrs),
        .o_minutes_bcd  (mins),
        .o_seconds_bcd  (secs),
        .o_sec_tick     (sec_tick),
        .o_day_rollover (day_roll)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        bcd = {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_tick();
        logic roll;
        roll = 1'b0;
        s++;
        if (s == 60) begin
            s = 0; m++;
            if (m == 60) begin
                m = 0; h++;
                if (h == 24) begin
                    h = 0; roll = 1'b1;
                end
            end
        end
        sb_q.push_back({roll, bcd(h), bcd(m), bcd(s)});
    endtask

    task automatic sec_edge(input string tag);
        logic [24:0] exp;
        bit seen;
        seen = 1'b0;
        model_tick();
        @(negedge clk);
        sec_clk = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (sec_tick === 1'b1) begin
                seen = 1'b1;
                exp = sb_q.pop_front();
                check(tag, {7'd0, day_roll, hrs, mins, secs}, {7'd0, exp});
`ifdef ALARM_EN
                alarm_at_tick = al_out;
`endif
            end
        end
        check({tag, "_tick_seen"}, 32'(seen), 32'd1);
        if (!seen) void'(sb_q.pop_front());
        @(negedge clk);
`ifdef ALARM_EN
        alarm_after_tick = al_out;
`endif
        check({tag, "_one_cycle"}, {30'd0, sec_tick, day_roll}, 32'd0);
        sec_clk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_pulse(input logic mn, input logic hr);
        @(negedge clk);
        inc_min = mn;
        inc_hr  = hr;
        @(negedge clk);
        inc_min = 1'b0;
        inc_hr  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_time", {8'd0, hrs, mins, secs}, 32'h0);
        check("reset_pulses", {30'd0, sec_tick, day_roll}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // latency from sec_clk_in rise to seconds update
        sec_clk = 1'b1;
        @(negedge clk);
        check("lat_edge1", {24'd0, secs}, 32'h00);
        @(negedge clk);
        check("lat_edge2", {24'd0, secs}, 32'h00);
        @(negedge clk);
        check("lat_edge3", {23'd0, sec_tick, secs}, {23'd0, 1'b1, 8'h01});
        sec_clk = 1'b0;
        repeat (3) @(negedge clk);

        // high input across reset release must not count
        sec_clk = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        base_tick = n_tick_seen;
        repeat (6) @(negedge clk);
        check("rst_high_no_tick", 32'(n_tick_seen - base_tick), 32'd0);
        check("rst_high_time", {8'd0, hrs, mins, secs}, 32'h0);
        sec_clk = 1'b0;
        repeat (3) @(negedge clk);
        h = 0; m = 0; s = 0;

        base_tick = n_tick_seen;
        for (int i = 0; i < 60; i++) sec_edge("t1_count");
        check("t1_ticks", 32'(n_tick_seen - base_tick), 32'd60);
        check("t1_end", {8'd0, hrs, mins, secs}, 32'h000100);

        set_pulse(1'b1, 1'b1);
        @(negedge clk);
        check("run_inc_ignored", {8'd0, hrs, mins, secs}, 32'h000100);

        set_mode = 1'b1;
        repeat (2) @(negedge clk);
        base_roll = n_roll_seen;
        for (int i = 0; i < 23; i++) set_pulse(1'b0, 1'b1);
        for (int i = 0; i < 58; i++) set_pulse(1'b1, 1'b0);
        check("t2_preload", {8'd0, hrs, mins, secs}, 32'h235900);
        set_mode = 1'b0;
        repeat (2) @(negedge clk);
        h = 23; m = 59; s = 0;
        base_roll = n_roll_seen;
        for (int i = 0; i < 60; i++) sec_edge("t2_wrap");
        check("t2_rollovers", 32'(n_roll_seen - base_roll), 32'd1);

        set_mode = 1'b1;
        repeat (2) @(negedge clk);
        base_tick = n_tick_seen;
        base_roll = n_roll_seen;
        for (int i = 0; i < 60; i++) set_pulse(1'b1, 1'b1);
        sec_clk = 1'b1;
        repeat (6) @(negedge clk);
        sec_clk = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_time", {8'd0, hrs, mins, secs}, 32'h120000);
        check("t4_no_tick", 32'(n_tick_seen - base_tick), 32'd0);
        check("t4_no_roll", 32'(n_roll_seen - base_roll), 32'd0);

        // tick coinciding with set_mode rising is dropped
        set_mode = 1'b0;
        repeat (2) @(negedge clk);
        base_tick = n_tick_seen;
        sec_clk = 1'b1;
        repeat (2) @(negedge clk);
        set_mode = 1'b1;
        repeat (4) @(negedge clk);
        check("drop_tick_none", 32'(n_tick_seen - base_tick), 32'd0);
        check("drop_tick_time", {8'd0, hrs, mins, secs}, 32'h120000);
        sec_clk = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 34; i++) set_pulse(1'b1, 1'b0);
        set_mode = 1'b0;
        repeat (2) @(negedge clk);
        h = 12; m = 34; s = 0;
        for (int i = 0; i < 56; i++) sec_edge("t5_run");
        check("t5_before_rst", {8'd0, hrs, mins, secs}, 32'h123456);
        #2 rst = 1'b1;
        #1 check("t5_async_rst", {7'd0, sec_tick, hrs, mins, secs}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        h = 0; m = 0; s = 0;
        repeat (2) @(negedge clk);

`ifdef ALARM_EN
        al_arm = 1'b1;
        for (int i = 0; i < 60; i++) sec_edge("t6_run");
        check("alarm_rise_at_match", 32'(alarm_at_tick), 32'd0);
        check("alarm_rise_next", 32'(alarm_after_tick), 32'd1);
        for (int i = 0; i < 60; i++) sec_edge("t6_run2");
        check("alarm_fall_at_end", 32'(alarm_at_tick), 32'd1);
        check("alarm_fall_next", 32'(alarm_after_tick), 32'd0);
        set_mode = 1'b1;
        repeat (2) @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 59; i++) begin
            set_pulse(1'b1, 1'b0);
            if (al_out === 1'b1) cnt++;
        end
        repeat (3) @(negedge clk);
        check("alarm_set_time", {8'd0, hrs, mins, secs}, 32'h000100);
        check("alarm_quiet_in_set", 32'(cnt) + 32'(al_out), 32'd0);
        set_mode = 1'b0;
        repeat (2) @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
